ln_lut_search: RTL
==================

LN_LUT_SEARCH -- requirements
Module: ln_lut_search

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 1_000_000, meaning the number of entries in the exp table.
REQ-002 SHALL have parameter IDX_W, default 20, meaning the table address width; ARRAY_SIZE <= 2^IDX_W.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  asynchronous active-high reset.
REQ-006 i_valid  input  1  request valid.
REQ-007 o_ready  output  1  block can accept a request.
REQ-008 i_value  input  64  y, an unsigned q32.32 value.
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  consumer accepts the result.
REQ-011 o_ln_value  output  64  x = ln(y), a signed q32.32 value in [-1,1].
REQ-012 o_index  output  IDX_W  table index of the result.
REQ-013 o_lut_rd  output  1  table read strobe.
REQ-014 o_lut_addr  output  IDX_W  table read address.
REQ-015 i_lut_data  input  64  table entry lut[addr], valid exactly 1 cycle after o_lut_rd; lut[i] = exp(-1 + 2i/(ARRAY_SIZE-1)) in q32.32, monotonic increasing.

Function
REQ-016 SHALL accept a request when i_valid && o_ready; o_ready SHALL be 1 only in IDLE.
REQ-017 SHALL capture i_value at acceptance; i_value changes after acceptance SHALL have no effect.
REQ-018 FSM states SHALL be IDLE, RD_LO, RD_HI, SRCH_ADDR, SRCH_WAIT, DONE.
REQ-019 IDLE->RD_LO on accept: SHALL read lut[0]; if y < lut[0], SHALL set index 0, set underflow, and go to DONE.
REQ-020 Otherwise SHALL go to RD_HI: read lut[ARRAY_SIZE-1]; if y >= lut[ARRAY_SIZE-1], SHALL set index ARRAY_SIZE-1, set overflow, and go to DONE.
REQ-021 Otherwise SHALL start the search with lo=0, hi=ARRAY_SIZE-1 and invariant lut[lo] <= y < lut[hi].
REQ-022 SRCH_ADDR: if hi-lo == 1, SHALL set index=lo and go to DONE; else SHALL issue a read at mid=(lo+hi)>>1 and go to SRCH_WAIT.
REQ-023 SRCH_WAIT: if lut[mid] <= y, SHALL set lo=mid, else hi=mid, and return to SRCH_ADDR.
REQ-024 Comparisons SHALL be unsigned 64-bit; equality SHALL resolve to the lower side, so y == lut[k] gives index k.
REQ-025 o_ln_value SHALL equal index*STEP - 2^32, computed in 64-bit two's complement, with localparam STEP = round(2^33/(ARRAY_SIZE-1)) (8590 at default).
REQ-026 DONE: o_valid=1, and o_ln_value, o_index and status SHALL stay stable until i_valid... until i_ready is seen high; on o_valid && i_ready SHALL go to IDLE.
REQ-027 Latency from acceptance to o_valid SHALL be <= 2*IDX_W + 6 cycles (<= 46 at default).
REQ-028 o_lut_rd SHALL be high for one cycle per read, with at most one outstanding read.
REQ-029 y = 0 SHALL be treated as underflow (index 0).
REQ-030 No new request SHALL be accepted in the cycle the result handshake completes; the earliest accept is the following cycle.

Reset
REQ-031 On i_reset, asynchronously: state=IDLE, o_ready=1 after release, o_valid=0, o_lut_rd=0, o_lut_addr=0, o_ln_value=0, o_index=0, status=0.
REQ-032 Reset mid-search or in DONE SHALL abandon the request; no result SHALL be produced for it.

Configuration
REQ-033 Macro LN_LUT_SEARCH_STATUS_EN defined: SHALL add output o_status [1:0] (bit0 underflow, bit1 overflow), valid with o_valid and 0 otherwise.
REQ-034 Macro undefined: o_status port and flag registers SHALL be absent; clamping behaviour SHALL be unchanged.

Verification
REQ-035 y = lut[500000] exactly -> o_index=500000, o_ln_value=0x0000_0000_0000_7FC0, status=00.
REQ-036 y = 0x0000_0000_0000_0000 -> o_index=0, o_ln_value=0xFFFF_FFFF_0000_0000, status=01, o_valid within 4 cycles of accept.
REQ-037 y = 0x0000_0005_0000_0000 (above e) -> o_index=999999, o_ln_value=0x0000_0001_0000_DDF2, status=10.
REQ-038 y = lut[1234]+1 -> o_index=1234; o_valid within 46 cycles; exactly one o_lut_rd per read cycle.
REQ-039 Hold i_ready=0 for 10 cycles in DONE -> outputs stable, o_ready=0, i_valid pulses ignored; then i_ready=1 -> IDLE next cycle.
REQ-040 Assert i_reset in SRCH_WAIT -> o_valid=0, o_lut_rd=0 immediately; after release, a new request y=lut[10] -> o_index=10.

Source files
------------

// File: rtl/ln_lut_search_if.sv
// ln_lut_search_if -- request/result handshake plus external table-read port
// for ln_lut_search.
//
// Parameter: IDX_W  table address width.
//
// Signals (names are from the block's point of view):
//   i_valid / o_ready / i_value     request handshake, y in unsigned q32.32
//   o_valid / i_ready               result handshake
//   o_ln_value / o_index            ln(y) in signed q32.32 and the table index
//   o_lut_rd / o_lut_addr           table read strobe and address
//   i_lut_data                      table entry, valid one cycle after o_lut_rd
//   o_status                        {overflow, underflow}; present only when
//                                   LN_LUT_SEARCH_STATUS_EN is defined
//
// Modports: slave = the search block, master = requester/consumer/table.
interface ln_lut_search_if #(
  parameter int unsigned IDX_W = 20
);
  logic             i_valid;
  logic             o_ready;
  logic [63:0]      i_value;
  logic             o_valid;
  logic             i_ready;
  logic [63:0]      o_ln_value;
  logic [IDX_W-1:0] o_index;
  logic             o_lut_rd;
  logic [IDX_W-1:0] o_lut_addr;
  logic [63:0]      i_lut_data;
`ifdef LN_LUT_SEARCH_STATUS_EN
  logic [1:0]       o_status;
`endif

  modport slave (
    input  i_valid, i_value, i_ready, i_lut_data,
    output o_ready, o_valid, o_ln_value, o_index, o_lut_rd, o_lut_addr
`ifdef LN_LUT_SEARCH_STATUS_EN
    , output o_status
`endif
  );

  modport master (
    output i_valid, i_value, i_ready, i_lut_data,
    input  o_ready, o_valid, o_ln_value, o_index, o_lut_rd, o_lut_addr
`ifdef LN_LUT_SEARCH_STATUS_EN
    , input o_status
`endif
  );
endinterface

// File: rtl/ln_lut_search.sv
// ln_lut_search -- natural log of an unsigned q32.32 value by binary search
// over an external, monotonically increasing exp() table with one-cycle read
// latency. The result index k satisfies lut[k] <= y < lut[k+1]; values below
// lut[0] clamp to index 0 (underflow), values at or above the last entry clamp
// to ARRAY_SIZE-1 (overflow). ln is reconstructed as k*STEP - 1.0.
//
// Parameters: ARRAY_SIZE  number of table entries (>= 2)
//             IDX_W       table address width, ARRAY_SIZE <= 2**IDX_W
// Ports:      i_clk       clock, rising edge
//             i_reset     asynchronous active-high reset
//             bus         ln_lut_search_if.slave (handshakes + table port)
// Option:     define LN_LUT_SEARCH_STATUS_EN to add bus.o_status
//             ({overflow, underflow}, valid with o_valid, 0 otherwise).
module ln_lut_search #(
  parameter int unsigned ARRAY_SIZE = 1_000_000,
  parameter int unsigned IDX_W      = 20
) (
  input  logic           i_clk,
  input  logic           i_reset,
  ln_lut_search_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ARRAY_SIZE - 1);
  localparam logic [63:0]      DIV  = 64'(ARRAY_SIZE - 1);
  // round(2^33 / (ARRAY_SIZE-1)): one index step expressed in q32.32
  localparam logic [63:0]      STEP = ((64'd1 << 33) + (DIV >> 1)) / DIV;
  localparam logic [63:0]      ONE  = 64'd1 << 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    SRCH_ADDR,
    SRCH_WAIT,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [63:0]      y, y_n;
  logic [IDX_W-1:0] lo, lo_n;
  logic [IDX_W-1:0] hi, hi_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [63:0]      ln, ln_n;
  logic             pend, pend_n;
`ifdef LN_LUT_SEARCH_STATUS_EN
  logic             flag_uf, flag_uf_n;
  logic             flag_of, flag_of_n;
`endif

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] mid;
  logic [IDX_W-1:0] span;

  function automatic logic [63:0] ln_of(input logic [IDX_W-1:0] k);
    return (64'(k) * STEP) - ONE;
  endfunction

  always_comb begin
    sum  = {1'b0, lo} + {1'b0, hi};
    mid  = IDX_W'(sum >> 1);
    span = hi - lo;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_n;
  end

  // RD_LO and RD_HI each take two cycles: the first issues the read (pend=0),
  // the second consumes i_lut_data (pend=1). The search loop needs no such
  // flag because SRCH_ADDR issues and SRCH_WAIT consumes.
  always_comb begin
    state_n = state;
    y_n     = y;
    lo_n    = lo;
    hi_n    = hi;
    idx_n   = idx;
    ln_n    = ln;
    pend_n  = 1'b0;
`ifdef LN_LUT_SEARCH_STATUS_EN
    flag_uf_n = flag_uf;
    flag_of_n = flag_of;
`endif
    bus.o_ready    = (state == IDLE);
    bus.o_valid    = (state == DONE);
    bus.o_lut_rd   = 1'b0;
    bus.o_lut_addr = '0;

    unique case (state)
      IDLE: begin
        if (bus.i_valid) begin
          y_n     = bus.i_value;
          state_n = RD_LO;
`ifdef LN_LUT_SEARCH_STATUS_EN
          flag_uf_n = 1'b0;
          flag_of_n = 1'b0;
`endif
        end
      end

      RD_LO: begin
        if (!pend) begin
          bus.o_lut_rd   = 1'b1;
          bus.o_lut_addr = '0;
          pend_n         = 1'b1;
        end else if (y < bus.i_lut_data) begin
          // also covers y == 0, since every table entry is positive
          idx_n   = '0;
          ln_n    = ln_of('0);
          state_n = DONE;
`ifdef LN_LUT_SEARCH_STATUS_EN
          flag_uf_n = 1'b1;
`endif
        end else begin
          state_n = RD_HI;
        end
      end

      RD_HI: begin
        if (!pend) begin
          bus.o_lut_rd   = 1'b1;
          bus.o_lut_addr = LAST;
          pend_n         = 1'b1;
        end else if (y >= bus.i_lut_data) begin
          idx_n   = LAST;
          ln_n    = ln_of(LAST);
          state_n = DONE;
`ifdef LN_LUT_SEARCH_STATUS_EN
          flag_of_n = 1'b1;
`endif
        end else begin
          lo_n    = '0;
          hi_n    = LAST;
          state_n = SRCH_ADDR;
        end
      end

      SRCH_ADDR: begin
        if (span == IDX_W'(1)) begin
          idx_n   = lo;
          ln_n    = ln_of(lo);
          state_n = DONE;
        end else begin
          bus.o_lut_rd   = 1'b1;
          bus.o_lut_addr = mid;
          state_n        = SRCH_WAIT;
        end
      end

      SRCH_WAIT: begin
        // equality moves lo up, keeping lut[lo] <= y < lut[hi]
        if (bus.i_lut_data <= y) lo_n = mid;
        else                     hi_n = mid;
        state_n = SRCH_ADDR;
      end

      DONE: begin
        if (bus.i_ready) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      y    <= '0;
      lo   <= '0;
      hi   <= '0;
      idx  <= '0;
      ln   <= '0;
      pend <= 1'b0;
`ifdef LN_LUT_SEARCH_STATUS_EN
      flag_uf <= 1'b0;
      flag_of <= 1'b0;
`endif
    end else begin
      y    <= y_n;
      lo   <= lo_n;
      hi   <= hi_n;
      idx  <= idx_n;
      ln   <= ln_n;
      pend <= pend_n;
`ifdef LN_LUT_SEARCH_STATUS_EN
      flag_uf <= flag_uf_n;
      flag_of <= flag_of_n;
`endif
    end
  end

  always_comb begin
    bus.o_index    = idx;
    bus.o_ln_value = ln;
`ifdef LN_LUT_SEARCH_STATUS_EN
    bus.o_status   = (state == DONE) ? {flag_of, flag_uf} : 2'b00;
`endif
  end

endmodule
